// File: rtl/switch_5x5_xy_pkg.sv
// Shared constants, port numbering and the destination-bit routing rule for switch_5x5_xy.
package switch_5x5_xy_pkg;

  localparam int unsigned DATA_W_DEF = 15;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned MSG_W_DEF  = DATA_W_DEF - ADDR_W_DEF;
  localparam int unsigned NUM_PORTS  = 5;

  typedef enum logic [2:0] {
    PortE  = 3'd0,
    PortN  = 3'd1,
    PortW  = 3'd2,
    PortS  = 3'd3,
    PortL1 = 3'd4
  } port_e;

  typedef struct packed {
    logic  valid;
    port_e port;
  } route_t;

  // First match wins: local, then X (E, W), then Y (N, S).
  function automatic route_t route_bit(input logic sid_hit, input logic e_hit,
                                       input logic w_hit, input logic n_hit,
                                       input logic s_hit);
    route_t r;
    r.valid = 1'b1;
    if (sid_hit)    r.port = PortL1;
    else if (e_hit) r.port = PortE;
    else if (w_hit) r.port = PortW;
    else if (n_hit) r.port = PortN;
    else if (s_hit) r.port = PortS;
    else begin
      r.valid = 1'b0;
      r.port  = PortE;
    end
    return r;
  endfunction

endpackage

// File: rtl/sw_in_port.sv
// One input of the switch: request synchronizer, one-packet slot, and a lowest-set-bit
// expander that presents one unicast packet at a time to the output arbiters.
module sw_in_port
  import switch_5x5_xy_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned MSG_W  = DATA_W - ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ack_o,
  input  logic [ADDR_W-1:0] sid_i,
  input  logic [ADDR_W-1:0] e_mask_i,
  input  logic [ADDR_W-1:0] w_mask_i,
  input  logic [ADDR_W-1:0] n_mask_i,
  input  logic [ADDR_W-1:0] s_mask_i,
  input  logic              grant_i,
  output logic              head_valid_o,
  output logic [2:0]        head_port_o,
  output logic [DATA_W-1:0] head_data_o
);

  logic              req_s1_q, req_s2_q, ack_q;
  logic [ADDR_W-1:0] mask_q, mask_d, low;
  logic [MSG_W-1:0]  msg_q;
  logic              full, load;
  route_t            route;

  // The slot is occupied exactly while address bits remain, so an all-zero
  // address is acked and leaves the slot empty.
  assign full = |mask_q;
  assign load = (req_s2_q != ack_q) && !full;
  assign low  = mask_q & (~mask_q + ADDR_W'(1));

  assign route = route_bit(|(low & sid_i), |(low & e_mask_i), |(low & w_mask_i),
                           |(low & n_mask_i), |(low & s_mask_i));

  always_comb begin
    mask_d = mask_q;
    // Unroutable bits are dropped one per cycle, just like granted ones.
    if (full && (grant_i || !route.valid)) mask_d = mask_q & ~low;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      req_s1_q <= 1'b0;
      req_s2_q <= 1'b0;
      ack_q    <= 1'b0;
      mask_q   <= '0;
      msg_q    <= '0;
    end else begin
      req_s1_q <= req_i;
      req_s2_q <= req_s1_q;
      if (load) begin
        mask_q <= data_i[ADDR_W-1:0];
        msg_q  <= data_i[DATA_W-1:ADDR_W];
        ack_q  <= ~ack_q;
      end else begin
        mask_q <= mask_d;
      end
    end
  end

  assign ack_o        = ack_q;
  assign head_valid_o = full && route.valid;
  assign head_port_o  = route.port;
  assign head_data_o  = {msg_q, low};

endmodule

// File: rtl/switch_5x5_xy.sv
// 5x5 two-phase bundled-data switch with XY multicast expansion and per-output
// round-robin arbitration. Port index order is E, N, W, S, L1.
module switch_5x5_xy
  import switch_5x5_xy_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned MSG_W  = DATA_W - ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ReqInE,
  input  logic [DATA_W-1:0] DataInE,
  output logic              AckInE,
  output logic              ReqOutE,
  output logic [DATA_W-1:0] DataOutE,
  input  logic              AckOutE,
  input  logic              ReqInN,
  input  logic [DATA_W-1:0] DataInN,
  output logic              AckInN,
  output logic              ReqOutN,
  output logic [DATA_W-1:0] DataOutN,
  input  logic              AckOutN,
  input  logic              ReqInW,
  input  logic [DATA_W-1:0] DataInW,
  output logic              AckInW,
  output logic              ReqOutW,
  output logic [DATA_W-1:0] DataOutW,
  input  logic              AckOutW,
  input  logic              ReqInS,
  input  logic [DATA_W-1:0] DataInS,
  output logic              AckInS,
  output logic              ReqOutS,
  output logic [DATA_W-1:0] DataOutS,
  input  logic              AckOutS,
  input  logic              ReqInL1,
  input  logic [DATA_W-1:0] DataInL1,
  output logic              AckInL1,
  output logic              ReqOutL1,
  output logic [DATA_W-1:0] DataOutL1,
  input  logic              AckOutL1,
  input  logic [ADDR_W-1:0] SID,
  input  logic [ADDR_W-1:0] E_MASK,
  input  logic [ADDR_W-1:0] W_MASK,
  input  logic [ADDR_W-1:0] N_MASK,
  input  logic [ADDR_W-1:0] S_MASK
);

  logic [NUM_PORTS-1:0] req_in, ack_in, ack_out;
  logic [DATA_W-1:0]    data_in [NUM_PORTS];
  logic [NUM_PORTS-1:0] head_valid, grant;
  logic [2:0]           head_port [NUM_PORTS];
  logic [DATA_W-1:0]    head_data [NUM_PORTS];

  assign req_in  = {ReqInL1, ReqInS, ReqInW, ReqInN, ReqInE};
  assign ack_out = {AckOutL1, AckOutS, AckOutW, AckOutN, AckOutE};
  assign data_in[0] = DataInE;
  assign data_in[1] = DataInN;
  assign data_in[2] = DataInW;
  assign data_in[3] = DataInS;
  assign data_in[4] = DataInL1;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_in
    sw_in_port #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W),
      .MSG_W (MSG_W)
    ) u_in (
      .clk         (clk),
      .reset       (reset),
      .req_i       (req_in[g]),
      .data_i      (data_in[g]),
      .ack_o       (ack_in[g]),
      .sid_i       (SID),
      .e_mask_i    (E_MASK),
      .w_mask_i    (W_MASK),
      .n_mask_i    (N_MASK),
      .s_mask_i    (S_MASK),
      .grant_i     (grant[g]),
      .head_valid_o(head_valid[g]),
      .head_port_o (head_port[g]),
      .head_data_o (head_data[g])
    );
  end

  logic [NUM_PORTS-1:0] ack_s1_q, ack_s2_q, req_out_q, out_free, win_valid;
  logic [2:0]           win_idx [NUM_PORTS];
  logic [2:0]           ptr_q [NUM_PORTS];
  logic [DATA_W-1:0]    data_out_q [NUM_PORTS];
  logic [3:0]           cand;

  always_comb begin
    out_free  = ~(req_out_q ^ ack_s2_q);
    grant     = '0;
    win_valid = '0;
    cand      = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      win_idx[o] = '0;
      // Scan inputs starting at the pointer; first requester wins.
      for (int k = 0; k < NUM_PORTS; k++) begin
        cand = {1'b0, ptr_q[o]} + 4'(k);
        if (cand >= 4'(NUM_PORTS)) cand = cand - 4'(NUM_PORTS);
        if (!win_valid[o] && head_valid[cand[2:0]] && head_port[cand[2:0]] == 3'(o)) begin
          win_valid[o] = 1'b1;
          win_idx[o]   = cand[2:0];
        end
      end
      if (win_valid[o] && out_free[o]) grant[win_idx[o]] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ack_s1_q  <= '0;
      ack_s2_q  <= '0;
      req_out_q <= '0;
      for (int o = 0; o < NUM_PORTS; o++) begin
        data_out_q[o] <= '0;
        ptr_q[o]      <= '0;
      end
    end else begin
      ack_s1_q <= ack_out;
      ack_s2_q <= ack_s1_q;
      for (int o = 0; o < NUM_PORTS; o++) begin
        if (win_valid[o] && out_free[o]) begin
          data_out_q[o] <= head_data[win_idx[o]];
          req_out_q[o]  <= ~req_out_q[o];
          ptr_q[o]      <= (win_idx[o] == 3'(NUM_PORTS - 1)) ? 3'd0 : win_idx[o] + 3'd1;
        end
      end
    end
  end

  assign {AckInL1, AckInS, AckInW, AckInN, AckInE}      = ack_in;
  assign {ReqOutL1, ReqOutS, ReqOutW, ReqOutN, ReqOutE} = req_out_q;
  assign DataOutE  = data_out_q[0];
  assign DataOutN  = data_out_q[1];
  assign DataOutW  = data_out_q[2];
  assign DataOutS  = data_out_q[3];
  assign DataOutL1 = data_out_q[4];

endmodule

// File: tb/tb_switch_5x5_xy.sv
// Self-checking bench for switch_5x5_xy: directed scenarios plus random traffic scored
// against per-(input, output) queues of expected unicast packets.
module tb_switch_5x5_xy;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_in [5];
  logic [14:0] data_in [5];
  logic        ack_in [5];
  logic        req_out [5];
  logic [14:0] data_out [5];
  logic        ack_out [5];
  logic [4:0]  sid, e_mask, w_mask, n_mask, s_mask;

  always #5 clk = ~clk;

  switch_5x5_xy dut (
    .clk      (clk),
    .reset    (reset),
    .ReqInE   (req_in[0]),  .DataInE  (data_in[0]), .AckInE  (ack_in[0]),
    .ReqOutE  (req_out[0]), .DataOutE (data_out[0]), .AckOutE (ack_out[0]),
    .ReqInN   (req_in[1]),  .DataInN  (data_in[1]), .AckInN  (ack_in[1]),
    .ReqOutN  (req_out[1]), .DataOutN (data_out[1]), .AckOutN (ack_out[1]),
    .ReqInW   (req_in[2]),  .DataInW  (data_in[2]), .AckInW  (ack_in[2]),
    .ReqOutW  (req_out[2]), .DataOutW (data_out[2]), .AckOutW (ack_out[2]),
    .ReqInS   (req_in[3]),  .DataInS  (data_in[3]), .AckInS  (ack_in[3]),
    .ReqOutS  (req_out[3]), .DataOutS (data_out[3]), .AckOutS (ack_out[3]),
    .ReqInL1  (req_in[4]),  .DataInL1 (data_in[4]), .AckInL1 (ack_in[4]),
    .ReqOutL1 (req_out[4]), .DataOutL1(data_out[4]), .AckOutL1(ack_out[4]),
    .SID      (sid),
    .E_MASK   (e_mask),
    .W_MASK   (w_mask),
    .N_MASK   (n_mask),
    .S_MASK   (s_mask)
  );

  int          n_tests = 0;
  int          n_fail = 0;
  logic [14:0] exp_q [5][5][$];
  logic [14:0] out_log [5][$];
  int          tog_cnt [5];
  int          base [5];
  logic [14:0] last_data [5];
  logic        last_req [5];
  int          ack_dly [5];
  bit          ack_pend [5];
  bit          hold [5];
  bit          mon_en = 1'b0;
  bit          found;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output index (E=0,N=1,W=2,S=3,L1=4) for destination bit j, -1 when unroutable.
  function automatic int route_of(input int j);
    if (sid[j])    return 4;
    if (e_mask[j]) return 0;
    if (w_mask[j]) return 2;
    if (n_mask[j]) return 1;
    if (s_mask[j]) return 3;
    return -1;
  endfunction

  task automatic model_push(input int i, input logic [14:0] pkt);
    for (int j = 0; j < 5; j++) begin
      if (pkt[j] && route_of(j) >= 0) exp_q[i][route_of(j)].push_back({pkt[14:5], 5'(1 << j)});
    end
  endtask

  // Downstream side: score each ReqOut toggle and answer it after a short random delay.
  always @(negedge clk) begin
    for (int o = 0; o < 5; o++) begin
      if (!mon_en) begin
        last_req[o] = req_out[o];
        ack_pend[o] = 1'b0;
      end else begin
        if (req_out[o] != last_req[o]) begin
          last_req[o]  = req_out[o];
          tog_cnt[o]++;
          last_data[o] = data_out[o];
          out_log[o].push_back(data_out[o]);
          found = 1'b0;
          for (int i = 0; i < 5; i++) begin
            if (!found && exp_q[i][o].size() > 0 && exp_q[i][o][0] == data_out[o]) begin
              found = 1'b1;
              void'(exp_q[i][o].pop_front());
            end
          end
          check($sformatf("out%0d_expected_pkt %0h", o, data_out[o]), found, 1);
          ack_pend[o] = 1'b1;
          ack_dly[o]  = $urandom_range(0, 3);
        end
        if (ack_pend[o]) begin
          if (ack_dly[o] > 0) ack_dly[o]--;
          else if (!hold[o]) begin
            ack_out[o]  = last_req[o];
            ack_pend[o] = 1'b0;
          end
        end
      end
    end
  end

  task automatic send(input int i, input logic [14:0] pkt);
    int t = 0;
    while (ack_in[i] != req_in[i] && t < 300) begin
      @(negedge clk);
      t++;
    end
    check($sformatf("in%0d_idle", i), ack_in[i] == req_in[i], 1);
    model_push(i, pkt);
    data_in[i] = pkt;
    req_in[i]  = ~req_in[i];
  endtask

  task automatic wait_ack(input int i);
    int t = 0;
    while (ack_in[i] != req_in[i] && t < 300) begin
      @(negedge clk);
      t++;
    end
    check($sformatf("in%0d_acked", i), ack_in[i] == req_in[i], 1);
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int t = 0; t < 20000 && !done; t++) begin
      @(negedge clk);
      done = 1'b1;
      for (int i = 0; i < 5; i++) begin
        if (ack_in[i] != req_in[i] || ack_pend[i]) done = 1'b0;
        for (int o = 0; o < 5; o++) if (exp_q[i][o].size() != 0) done = 1'b0;
      end
    end
    check("drain", done, 1);
  endtask

  task automatic snap();
    for (int o = 0; o < 5; o++) base[o] = tog_cnt[o];
  endtask

  task automatic check_delta(input string tag, input int o, input int d);
    check($sformatf("%s_out%0d_toggles", tag, o), tog_cnt[o] - base[o], d);
  endtask

  task automatic default_masks();
    sid = 5'b00001; e_mask = 5'b00010; n_mask = 5'b00100; w_mask = 5'b01000; s_mask = 5'b10000;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ack_edge, rq_edge, t;
    logic [14:0] pa, pb, pc;
    for (int i = 0; i < 5; i++) begin
      req_in[i] = 1'b0; data_in[i] = '0; ack_out[i] = 1'b0;
      hold[i] = 1'b0; tog_cnt[i] = 0; ack_dly[i] = 0;
    end
    default_masks();
    repeat (3) @(negedge clk);
    for (int o = 0; o < 5; o++) check($sformatf("rst_out%0d", o), {req_out[o], data_out[o], ack_in[o]}, 0);
    reset  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    // L1 -> E unicast, with handshake latency.
    snap();
    send(4, {10'h155, 5'b00010});
    ack_edge = 0; rq_edge = 0;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk); #1;
      if (ack_in[4] && ack_edge == 0) ack_edge = e;
      if (req_out[0] && rq_edge == 0) rq_edge = e;
    end
    @(negedge clk);
    check("lat_ackin", ack_edge, 3);
    check("lat_reqout", rq_edge, 4);
    drain();
    for (int o = 0; o < 5; o++) check_delta("l1_to_e", o, (o == 0) ? 1 : 0);
    check("l1_to_e_data", last_data[0], {10'h155, 5'b00010});
    check("l1_to_e_ackin", ack_in[4], 1);

    // Collision at L1 from E and N with the L1 pointer at E.
    snap();
    out_log[4].delete();
    send(0, {10'h011, 5'b00001});
    send(1, {10'h022, 5'b00001});
    drain();
    check("coll1_count", out_log[4].size(), 2);
    check("coll1_first", out_log[4][0], {10'h011, 5'b00001});
    check("coll1_second", out_log[4][1], {10'h022, 5'b00001});

    // Full multicast from E; its L1 grant leaves the L1 pointer at N.
    snap();
    send(0, {10'h0A3, 5'b11111});
    drain();
    for (int o = 0; o < 5; o++) begin
      check_delta("mcast", o, 1);
      check($sformatf("mcast_data%0d", o), last_data[o], {10'h0A3, 5'(1 << ((o == 4) ? 0 : o + 1))});
    end

    // Repeat collision: pointer now at N.
    out_log[4].delete();
    send(0, {10'h033, 5'b00001});
    send(1, {10'h044, 5'b00001});
    drain();
    check("coll2_count", out_log[4].size(), 2);
    check("coll2_first", out_log[4][0], {10'h044, 5'b00001});
    check("coll2_second", out_log[4][1], {10'h033, 5'b00001});

    // Back-pressure: L1 output ack held.
    snap();
    hold[4] = 1'b1;
    pa = {10'h101, 5'b00001}; pb = {10'h102, 5'b00001}; pc = {10'h103, 5'b00001};
    send(4, pa);
    wait_ack(4);
    repeat (3) @(negedge clk);
    check_delta("bp_first", 4, 1);
    send(4, pb);
    wait_ack(4);
    send(4, pc);
    repeat (20) @(negedge clk);
    check("bp_stall", ack_in[4] != req_in[4], 1);
    check_delta("bp_stall", 4, 1);
    hold[4] = 1'b0;
    wait_ack(4);
    drain();
    check_delta("bp_done", 4, 3);

    // Zero address, then partially unroutable address.
    snap();
    send(2, {10'h0F0, 5'b00000});
    wait_ack(2);
    repeat (10) @(negedge clk);
    for (int o = 0; o < 5; o++) check_delta("zero_addr", o, 0);
    n_mask = 5'b00000;
    send(3, {10'h0F1, 5'b00110});
    wait_ack(3);
    drain();
    for (int o = 0; o < 5; o++) check_delta("discard", o, (o == 0) ? 1 : 0);
    check("discard_data", last_data[0], {10'h0F1, 5'b00010});
    default_masks();

    // Random traffic, spec masks then random masks.
    for (int phase = 0; phase < 2; phase++) begin
      if (phase == 1) begin
        sid = 5'(1 << $urandom_range(0, 4));
        e_mask = 5'($urandom); w_mask = 5'($urandom); n_mask = 5'($urandom); s_mask = 5'($urandom);
      end
      for (int n = 0; n < 150; n++) begin
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
          if (ack_in[i] == req_in[i] && $urandom_range(0, 2) == 0) send(i, 15'($urandom));
        end
      end
      drain();
    end
    default_masks();

    // Reset in the middle of a multicast.
    snap();
    send(0, {10'h2AA, 5'b11111});
    t = 0;
    while ((tog_cnt[0] + tog_cnt[1] + tog_cnt[2] + tog_cnt[3] + tog_cnt[4]
            - base[0] - base[1] - base[2] - base[3] - base[4]) < 2 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("mid_reset_started", t < 100, 1);
    reset  = 1'b0;
    mon_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req_in[i] = 1'b0; ack_out[i] = 1'b0;
      for (int o = 0; o < 5; o++) exp_q[i][o].delete();
    end
    repeat (2) @(negedge clk);
    for (int o = 0; o < 5; o++) check($sformatf("mid_rst_out%0d", o), {req_out[o], data_out[o], ack_in[o]}, 0);
    reset  = 1'b1;
    mon_en = 1'b1;
    snap();
    repeat (20) @(negedge clk);
    for (int o = 0; o < 5; o++) check_delta("post_reset_quiet", o, 0);
    send(4, {10'h3C3, 5'b00010});
    wait_ack(4);
    drain();
    check_delta("post_reset_first", 0, 1);
    check("post_reset_data", last_data[0], {10'h3C3, 5'b00010});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
